mem_store_narrow: RTL

//   Store-side partner of the immediate/load extender: narrows a 32-bit store operand to byte/half/word.

---
 rtl/mem_store_narrow.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_store_narrow.sv
// ----------------------------------------------------------------------------
// mem_store_narrow
//   Store-side narrowing unit between the MEM stage and the data-memory port.
//   Turns a 32-bit store operand plus byte address and size into a
//   word-aligned memory write with lane-replicated data and byte enables.
//   Misaligned stores and the illegal size are rejected with a one-cycle
//   st_misalign pulse and never reach memory.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined   : a request left unacknowledged for TIMEOUT_CYCLES cycles is
//                 abandoned and reported with a one-cycle st_timeout pulse.
//     undefined : the unit waits for mem_ack indefinitely; st_timeout is 0.
//
//   Handshake: st_ready is high only in IDLE; a store is taken on a rising
//   edge where st_valid && st_ready. mem_req is held with stable
//   mem_addr/mem_wdata/mem_be until a rising edge samples mem_ack high.
//   mem_ack outside a request is ignored.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   st_valid     in   1   store request from pipeline
//   st_ready     out  1   unit idle, store can be accepted
//   st_addr      in   32  byte address of store
//   st_data      in   32  store operand (low 8/16/32 bits used)
//   st_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   st_done      out  1   pulse: store committed
//   st_misalign  out  1   pulse: store rejected
//   st_timeout   out  1   pulse: store aborted without ack
//   mem_req      out  1   write request to data memory
//   mem_addr     out  32  word address
//   mem_wdata    out  32  lane-replicated write data
//   mem_be       out  4   byte enables, bit i = lane i
//   mem_ack      in   1   memory accepted the write
// ----------------------------------------------------------------------------
module mem_store_narrow #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_done,
    output logic        st_misalign,
    output logic        st_timeout,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        accept;
    logic        misaligned;
    logic        expire;
    logic [31:0] narrow_wdata;
    logic [3:0]  narrow_be;
    logic        done_q;
    logic        timeout_q;

    assign accept = st_valid && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (st_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = st_addr[0];
            2'b10:   misaligned = |st_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Data is replicated across all lanes so memory can pick any lane; the
    // byte enables select the lanes actually written.
    always_comb begin
        narrow_wdata = st_data;
        narrow_be    = 4'b0000;
        case (st_size)
            2'b00: begin
                narrow_wdata = {4{st_data[7:0]}};
                narrow_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                narrow_wdata = {2{st_data[15:0]}};
                narrow_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                narrow_wdata = st_data;
                narrow_be    = 4'b1111;
            end
            default: begin
                narrow_wdata = st_data;
                narrow_be    = 4'b0000;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // wait_cnt holds the number of REQ cycles already spent without ack, so
    // the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == REQ && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // An ack on the final cycle takes priority over the timeout.
    assign expire = (state == REQ) && !mem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = misaligned ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_ack || expire) begin
                    state_nxt = IDLE;
                end
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address/data keep their last value after a store; enables are only
    // non-zero while the request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (accept) begin
            mem_addr  <= {st_addr[31:2], 2'b00};
            mem_wdata <= narrow_wdata;
            mem_be    <= misaligned ? 4'b0000 : narrow_be;
        end else if (state == REQ && state_nxt != REQ) begin
            mem_be    <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= (state == REQ) && mem_ack;
            timeout_q <= expire;
        end
    end

    assign st_ready    = (state == IDLE);
    assign mem_req     = (state == REQ);
    assign st_misalign = (state == ERR);
    assign st_done     = done_q;
    assign st_timeout  = timeout_q;

endmodule
